cdb_arbiter: RTL and testbench

- Producer end of the tag-return path. Collects completed results from NUM_EU execution units and broadcasts one result per cycle on the common data bus (CDB).
- The broadcast tag drives the dispatcher's free-tag FIFO write port, which recycles the tag. The same bus also feeds register-file and reservation-station wakeup.
- Each unit has a one-entry holding register with a valid/ready handshake. Arbitration is round-robin. Broadcast is stalled while the tag FIFO reports full.

---
 rtl/cdb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/cdb_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB constants and result-bus type. The tag FIFO and the dispatcher
// import the same package so that tag widths always agree.
package cdb_pkg;

   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;
   localparam int RD_W   = 5;
   localparam int NUM_EU = 4;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic [RD_W-1:0]   rd;
   } cdb_t;

   // Modular add for indices already reduced below n.
   function automatic int unsigned wrap_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned n);
      int unsigned s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, wrapping at N,
// and returns a one-hot grant plus its encoded index.
module rr_arbiter
   import cdb_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   int unsigned      cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand     = wrap_add(32'(ptr), k, 32'(N));
         cand_idx = cand[IDX_W-1:0];
         if (!grant_any && req[cand_idx]) begin
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
            grant_any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding register per execution unit, round-robin
// selection, one registered broadcast per cycle, stalled while the tag FIFO is full.
module cdb_arbiter #(
   parameter int NUM_EU = cdb_pkg::NUM_EU,
   parameter int TAG_W  = cdb_pkg::TAG_W,
   parameter int DATA_W = cdb_pkg::DATA_W,
   parameter int RD_W   = cdb_pkg::RD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_EU-1:0]          eu_valid,
   input  logic [NUM_EU*TAG_W-1:0]    eu_tag,
   input  logic [NUM_EU*DATA_W-1:0]   eu_data,
   input  logic [NUM_EU*RD_W-1:0]     eu_rd,
   output logic [NUM_EU-1:0]          eu_ready,
   input  logic                       tf_full,
   output logic                       cdb_valid,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [DATA_W-1:0]          cdb_data,
   output logic [RD_W-1:0]            cdb_rd,
   output logic [$clog2(NUM_EU)-1:0]  cdb_src
);

   localparam int SRC_W = $clog2(NUM_EU);

   logic [NUM_EU-1:0] hold_v;
   logic [TAG_W-1:0]  hold_tag  [NUM_EU];
   logic [DATA_W-1:0] hold_data [NUM_EU];
   logic [RD_W-1:0]   hold_rd   [NUM_EU];

   logic [NUM_EU-1:0] req;
   logic [NUM_EU-1:0] grant;
   logic [NUM_EU-1:0] accept;
   logic [SRC_W-1:0]  grant_idx;
   logic              grant_any;
   logic [SRC_W-1:0]  rr_ptr;

   // A full tag FIFO masks every request, so nothing leaves the holding registers.
   assign req = tf_full ? '0 : hold_v;

   rr_arbiter #(
      .N     (NUM_EU),
      .IDX_W (SRC_W)
   ) u_rr (
      .req       (req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Granted entries are free again this cycle, which lets a lone unit stream.
   assign eu_ready = ~hold_v | grant;
   assign accept   = eu_valid & eu_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_v <= '0;
         for (int i = 0; i < NUM_EU; i++) begin
            hold_tag[i]  <= '0;
            hold_data[i] <= '0;
            hold_rd[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_EU; i++) begin
            if (accept[i]) begin
               hold_v[i]    <= 1'b1;
               hold_tag[i]  <= eu_tag[i*TAG_W +: TAG_W];
               hold_data[i] <= eu_data[i*DATA_W +: DATA_W];
               hold_rd[i]   <= eu_rd[i*RD_W +: RD_W];
            end else if (grant[i]) begin
               hold_v[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant_any) begin
         rr_ptr <= SRC_W'(cdb_pkg::wrap_add(32'(grant_idx), 32'd1, 32'(NUM_EU)));
      end
   end

   // Payload fields keep their last value when idle; only cdb_valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_rd    <= '0;
         cdb_src   <= '0;
      end else begin
         cdb_valid <= grant_any;
         if (grant_any) begin
            cdb_tag  <= hold_tag[grant_idx];
            cdb_data <= hold_data[grant_idx];
            cdb_rd   <= hold_rd[grant_idx];
            cdb_src  <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// every broadcast; an independent monitor pops and compares at each negedge.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 6;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    eu_valid;
   logic [N*TW-1:0] eu_tag;
   logic [N*DW-1:0] eu_data;
   logic [N*RW-1:0] eu_rd;
   logic [N-1:0]    eu_ready;
   logic            tf_full;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [RW-1:0]   cdb_rd;
   logic [SW-1:0]   cdb_src;

   cdb_arbiter #(.NUM_EU(N), .TAG_W(TW), .DATA_W(DW), .RD_W(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .eu_valid  (eu_valid),
      .eu_tag    (eu_tag),
      .eu_data   (eu_data),
      .eu_rd     (eu_rd),
      .eu_ready  (eu_ready),
      .tf_full   (tf_full),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_rd    (cdb_rd),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic [RW-1:0] rd;
      int            src;
   } item_t;

   item_t         sb[$];
   logic [TW-1:0] obs_tag[$];
   logic [TW-1:0] exp_seq[$];
   int            checks = 0;
   int            errors = 0;

   // producers: offer held until the model says it was accepted
   bit            prod_v[N];
   logic [TW-1:0] prod_tag[N];
   logic [DW-1:0] prod_data[N];
   logic [RW-1:0] prod_rd[N];

   // reference model: at most one pending result per unit, fair pointer
   bit            m_hv[N];
   logic [TW-1:0] m_tag[N];
   logic [DW-1:0] m_data[N];
   logic [RW-1:0] m_rd[N];
   int            m_ptr = 0;
   bit            exp_valid = 1'b0;

   function automatic int model_grant();
      if (tf_full) return -1;
      for (int k = 0; k < N; k++) begin
         if (m_hv[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_ptr     = 0;
      exp_valid = 1'b0;
      sb.delete();
   endtask

   task automatic offer(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d,
                        input logic [RW-1:0] r);
      prod_v[u]    = 1'b1;
      prod_tag[u]  = t;
      prod_data[u] = d;
      prod_rd[u]   = r;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         eu_valid[i]          = prod_v[i];
         eu_tag[i*TW +: TW]   = prod_tag[i];
         eu_data[i*DW +: DW]  = prod_data[i];
         eu_rd[i*RW +: RW]    = prod_rd[i];
      end
   endtask

   // One clock cycle: starts and ends just after a negedge.
   task automatic step();
      int           g;
      logic [N-1:0] exp_rdy;
      item_t        it;
      drive();
      #1;
      g = model_grant();
      for (int i = 0; i < N; i++) exp_rdy[i] = !m_hv[i] || (g == i);
      checks++;
      if (eu_ready !== exp_rdy) begin
         errors++;
         $display("FAIL eu_ready at %0t: got %b expected %b", $time, eu_ready, exp_rdy);
      end
      @(posedge clk);
      if (g >= 0) begin
         it.tag  = m_tag[g];
         it.data = m_data[g];
         it.rd   = m_rd[g];
         it.src  = g;
         sb.push_back(it);
         m_hv[g]   = 1'b0;
         m_ptr     = (g + 1) % N;
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (prod_v[i] && exp_rdy[i]) begin
            m_hv[i]   = 1'b1;
            m_tag[i]  = prod_tag[i];
            m_data[i] = prod_data[i];
            m_rd[i]   = prod_rd[i];
            prod_v[i] = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic check_seq(input string name);
      bit    ok;
      string s_got, s_exp;
      ok = (obs_tag.size() == exp_seq.size());
      s_got = "";
      s_exp = "";
      foreach (obs_tag[i]) s_got = $sformatf("%s %h", s_got, obs_tag[i]);
      foreach (exp_seq[i]) begin
         s_exp = $sformatf("%s %h", s_exp, exp_seq[i]);
         if (ok && obs_tag[i] !== exp_seq[i]) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got tags [%s ] expected [%s ]", name, s_got, s_exp);
      end
      obs_tag.delete();
   endtask

   // monitor: every broadcast must match the oldest predicted result
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            checks++;
            if (cdb_valid !== exp_valid) begin
               errors++;
               $display("FAIL cdb_valid at %0t: got %b expected %b", $time, cdb_valid, exp_valid);
            end
            if (cdb_valid === 1'b1) begin
               obs_tag.push_back(cdb_tag);
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL cdb_unexpected at %0t: got tag %h expected no broadcast", $time, cdb_tag);
               end else begin
                  it = sb.pop_front();
                  if (cdb_tag !== it.tag || cdb_data !== it.data || cdb_rd !== it.rd ||
                      cdb_src !== SW'(it.src)) begin
                     errors++;
                     $display("FAIL cdb_payload at %0t: got tag %h data %h rd %0d src %0d expected tag %h data %h rd %0d src %0d",
                              $time, cdb_tag, cdb_data, cdb_rd, cdb_src, it.tag, it.data, it.rd, it.src);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      tf_full  = 1'b0;
      eu_valid = '0;
      eu_tag   = '0;
      eu_data  = '0;
      eu_rd    = '0;
      for (int i = 0; i < N; i++) prod_v[i] = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({cdb_valid, cdb_tag, cdb_data, cdb_rd, cdb_src} !== '0 || eu_ready !== 4'hF) begin
         errors++;
         $display("FAIL reset_state: got valid %b tag %h data %h rd %0d src %0d ready %b expected all zero, ready 1111",
                  cdb_valid, cdb_tag, cdb_data, cdb_rd, cdb_src, eu_ready);
      end
      rst = 1'b0;
      @(negedge clk);

      // single result from unit 1
      offer(1, 6'h05, 32'hDEADBEEF, 5'd3);
      step();
      idle(3);
      exp_seq = '{6'h05};
      check_seq("single");

      // unit 2 streams alone via refill-on-grant
      for (int t = 0; t < 3; t++) begin
         offer(2, 6'(8'h20 + t), $urandom, 5'(t + 7));
         step();
      end
      idle(3);
      exp_seq = '{6'h20, 6'h21, 6'h22};
      check_seq("stream");

      // pointer now at 3: wrap to unit 0
      offer(3, 6'h3A, 32'h0000_003A, 5'd10);
      offer(0, 6'h0A, 32'h0000_000A, 5'd11);
      step();
      idle(3);
      exp_seq = '{6'h3A, 6'h0A};
      check_seq("wrap");

      // pointer should now be 1
      for (int i = 0; i < N; i++) offer(i, 6'(8'h28 + i), $urandom, 5'(i));
      step();
      idle(5);
      exp_seq = '{6'h29, 6'h2A, 6'h2B, 6'h28};
      check_seq("ptr_after_wrap");

      // reset while three entries are held and a broadcast is on the bus
      for (int i = 0; i < N; i++) offer(i, 6'(i), $urandom, 5'(i + 1));
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || eu_ready !== 4'hF) begin
         errors++;
         $display("FAIL mid_reset: got valid %b tag %h ready %b expected valid 0 tag 00 ready 1111",
                  cdb_valid, cdb_tag, eu_ready);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      obs_tag.delete();
      idle(3);
      exp_seq.delete();
      check_seq("reset_discard");

      // fairness from pointer 0, twice
      for (int i = 0; i < N; i++) offer(i, 6'(8'h10 + i), $urandom, 5'(i));
      step();
      idle(5);
      for (int i = 0; i < N; i++) offer(i, 6'(8'h14 + i), $urandom, 5'(i + 4));
      step();
      idle(5);
      exp_seq = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17};
      check_seq("round_robin");

      // back-pressure from a full tag FIFO
      tf_full = 1'b1;
      offer(0, 6'h30, 32'h3030_3030, 5'd30);
      offer(3, 6'h33, 32'h3333_3333, 5'd31);
      repeat (5) step();
      tf_full = 1'b0;
      idle(4);
      exp_seq = '{6'h30, 6'h33};
      check_seq("backpressure");

      // randomized traffic with random stalls
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tf_full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            if (!prod_v[i] && $urandom_range(0, 99) < 55)
               offer(i, TW'($urandom), $urandom, RW'($urandom));
         end
         step();
      end
      tf_full = 1'b0;
      idle(12);
      checks++;
      if (sb.size() != 0 || prod_v[0] || prod_v[1] || prod_v[2] || prod_v[3]) begin
         errors++;
         $display("FAIL drain: got %0d results still pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
